valu_seq_ctrl: RTL

- Parametrised vector-ALU sequencer, successor to the single-cycle vector ALU control decoder.
- Accepts one decoded vector instruction ({funct6, vm, funct3}) plus a vector length.
- Emits a stream of per-beat lane controls: ALU op, lane enable, mask enable, accumulator control.
- Processes LANES elements per beat. Sits between the vector decode stage and the lane datapath; adds multi-beat sequencing, tail masking, masked ops, dot-product accumulate/reduce and valid/ready handshakes.

---
 rtl/valu_pkg.sv | 33 +++
 rtl/valu_op_decode.sv | 42 ++++
 rtl/valu_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/valu_pkg.sv
// Shared types and encodings for the vector-ALU sequencer and its decoder.
package valu_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_SMUL,
        OP_DOT
    } valu_op_e;

    localparam logic [2:0] VALU_CTRL_ADD  = 3'b010;
    localparam logic [2:0] VALU_CTRL_SUB  = 3'b110;
    localparam logic [2:0] VALU_CTRL_SMUL = 3'b000;
    localparam logic [2:0] VALU_CTRL_DOT  = 3'b001;

    localparam logic [5:0] F6_ADD  = 6'b000000;
    localparam logic [5:0] F6_SUB  = 6'b010000;
    localparam logic [5:0] F6_SMUL = 6'b000000;
    localparam logic [5:0] F6_DOT  = 6'b000000;

    localparam logic [2:0] F3_ADD  = 3'b001;
    localparam logic [2:0] F3_SUB  = 3'b000;
    localparam logic [2:0] F3_SMUL = 3'b111;
    localparam logic [2:0] F3_DOT  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_REDUCE,
        ST_DONE
    } valu_state_e;

endpackage

// File: rtl/valu_op_decode.sv
// Combinational decode of {funct6, vm, funct3} into op, ALU control and legality.
module valu_op_decode
    import valu_pkg::*;
(
    input  logic [9:0] vfunct_i,
    output valu_op_e   op_o,
    output logic [2:0] ctrl_o,
    output logic       legal_o,
    output logic       mask_en_o
);

    logic [5:0] funct6;
    logic [2:0] funct3;

    assign funct6    = vfunct_i[9:4];
    assign funct3    = vfunct_i[2:0];
    assign mask_en_o = ~vfunct_i[3];

    always_comb begin
        op_o    = OP_ADD;
        ctrl_o  = 3'b000;
        legal_o = 1'b0;
        case ({funct6, funct3})
            {F6_ADD, F3_ADD}: begin
                op_o = OP_ADD;  ctrl_o = VALU_CTRL_ADD;  legal_o = 1'b1;
            end
            {F6_SUB, F3_SUB}: begin
                op_o = OP_SUB;  ctrl_o = VALU_CTRL_SUB;  legal_o = 1'b1;
            end
            {F6_SMUL, F3_SMUL}: begin
                op_o = OP_SMUL; ctrl_o = VALU_CTRL_SMUL; legal_o = 1'b1;
            end
            {F6_DOT, F3_DOT}: begin
                op_o = OP_DOT;  ctrl_o = VALU_CTRL_DOT;  legal_o = 1'b1;
            end
            default: begin
                op_o = OP_ADD;  ctrl_o = 3'b000;         legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/valu_seq_ctrl.sv
// Multi-beat vector-ALU sequencer: turns one decoded instruction into per-beat lane controls.
// state     | meaning
// ST_IDLE   | ready for a new instruction
// ST_EXEC   | issuing element beats, one per beat_ready_i
// ST_REDUCE | DOT only: one cross-lane reduce step
// ST_DONE   | one-cycle completion pulse (illegal_o qualifies it)
module valu_seq_ctrl
    import valu_pkg::*;
#(
    parameter int VLEN_MAX = 32,
    parameter int LANES    = 4,
    parameter int VL_W     = $clog2(VLEN_MAX + 1),
    parameter int BI_W     = ((VLEN_MAX / LANES) > 1) ? $clog2(VLEN_MAX / LANES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [9:0]       vfunct_i,
    input  logic [VL_W-1:0]  vl_i,
    output logic             beat_valid_o,
    input  logic             beat_ready_i,
    output logic [2:0]       valu_ctrl_o,
    output logic [BI_W-1:0]  beat_idx_o,
    output logic [LANES-1:0] lane_en_o,
    output logic             mask_en_o,
    output logic             acc_clr_o,
    output logic             acc_en_o,
    output logic             reduce_o,
    output logic             done_o,
    output logic             illegal_o
);

    localparam int              LG_L       = $clog2(LANES);
    localparam logic [VL_W-1:0] VLEN_MAX_V = VL_W'(VLEN_MAX);

    valu_state_e     state_q, state_d;
    valu_op_e        op_q, op_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            mask_q, mask_d;
    logic            illegal_q, illegal_d;
    logic [VL_W-1:0] vle_q, vle_d;
    logic [BI_W-1:0] beat_idx_q, beat_idx_d;

    valu_op_e        dec_op;
    logic [2:0]      dec_ctrl;
    logic            dec_legal;
    logic            dec_mask_en;
    logic [VL_W-1:0] vle_in;
    logic [VL_W-1:0] vle_m1;
    logic [BI_W-1:0] last_beat;

    valu_op_decode u_dec (
        .vfunct_i  (vfunct_i),
        .op_o      (dec_op),
        .ctrl_o    (dec_ctrl),
        .legal_o   (dec_legal),
        .mask_en_o (dec_mask_en)
    );

    assign vle_in    = (vl_i > VLEN_MAX_V) ? VLEN_MAX_V : vl_i;
    assign vle_m1    = vle_q - VL_W'(1);
    assign last_beat = BI_W'(vle_m1 >> LG_L);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ctrl_d       = ctrl_q;
        mask_d       = mask_q;
        illegal_d    = illegal_q;
        vle_d        = vle_q;
        beat_idx_d   = beat_idx_q;
        in_ready_o   = 1'b0;
        beat_valid_o = 1'b0;
        valu_ctrl_o  = 3'b000;
        beat_idx_o   = '0;
        lane_en_o    = '0;
        mask_en_o    = 1'b0;
        acc_clr_o    = 1'b0;
        acc_en_o     = 1'b0;
        reduce_o     = 1'b0;
        done_o       = 1'b0;
        illegal_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    op_d       = dec_op;
                    ctrl_d     = dec_ctrl;
                    mask_d     = dec_mask_en;
                    illegal_d  = ~dec_legal;
                    vle_d      = vle_in;
                    beat_idx_d = '0;
                    state_d    = (!dec_legal || vle_in == '0) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                beat_valid_o = 1'b1;
                valu_ctrl_o  = ctrl_q;
                mask_en_o    = mask_q;
                beat_idx_o   = beat_idx_q;
                for (int l = 0; l < LANES; l++) begin
                    lane_en_o[l] = (int'(beat_idx_q) * LANES + l) < int'(vle_q);
                end
                if (op_q == OP_DOT) begin
                    acc_en_o  = 1'b1;
                    acc_clr_o = (beat_idx_q == '0);
                end
                if (beat_ready_i) begin
                    if (beat_idx_q == last_beat) begin
                        state_d = (op_q == OP_DOT) ? ST_REDUCE : ST_DONE;
                    end else begin
                        beat_idx_d = beat_idx_q + BI_W'(1);
                    end
                end
            end
            ST_REDUCE: begin
                beat_valid_o = 1'b1;
                reduce_o     = 1'b1;
                lane_en_o    = '1;
                if (beat_ready_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                illegal_o = illegal_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are forced quiet for the whole reset window, not just after the first edge.
        if (rst_i) begin
            in_ready_o   = 1'b0;
            beat_valid_o = 1'b0;
            valu_ctrl_o  = 3'b000;
            beat_idx_o   = '0;
            lane_en_o    = '0;
            mask_en_o    = 1'b0;
            acc_clr_o    = 1'b0;
            acc_en_o     = 1'b0;
            reduce_o     = 1'b0;
            done_o       = 1'b0;
            illegal_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            ctrl_q     <= 3'b000;
            mask_q     <= 1'b0;
            illegal_q  <= 1'b0;
            vle_q      <= '0;
            beat_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ctrl_q     <= ctrl_d;
            mask_q     <= mask_d;
            illegal_q  <= illegal_d;
            vle_q      <= vle_d;
            beat_idx_q <= beat_idx_d;
        end
    end

endmodule
